// File: rtl/spi_out_pkg.sv
// Shared types and helpers for the SPI output framer.
// SPI_PARITY_EN appends an even-parity bit to every frame.
package spi_out_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   function automatic int frame_w(input int addr_w, input int data_w);
`ifdef SPI_PARITY_EN
      return addr_w + data_w + 1;
`else
      return addr_w + data_w;
`endif
   endfunction

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic parity_even(input logic [39:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/spi_out_fifo.sv
// Synchronous word FIFO with registered occupancy and full flag.
module spi_out_fifo
   import spi_out_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [AW-1:0]                wr_ptr, rd_ptr;
   logic [AW:0]                  level_q, level_nx;
   logic                         full_q;
   logic                         push, pop;

   // A pop in the same cycle never frees room for a push: full is registered.
   assign push    = wr_en && !full_q;
   assign pop     = rd_en && !empty;
   assign empty   = (level_q == '0);
   assign rd_data = mem[rd_ptr];
   assign level   = level_q;
   assign full    = full_q;

   always_comb begin
      level_nx = level_q;
      case ({push, pop})
         2'b10:   level_nx = level_q + (AW+1)'(1);
         2'b01:   level_nx = level_q - (AW+1)'(1);
         default: level_nx = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level_q <= level_nx;
         full_q  <= (level_nx == (AW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/output_spi_framer.sv
// FIFO-buffered SPI output framer: {ADDR, DATA[, parity]} shifted out per word.
// Optional SPI_PARITY_EN adds a trailing even-parity bit to each frame.
module output_spi_framer
   import spi_out_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int ADDR      = 1,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1,
   parameter int GAP       = 1
) (
   input  logic                       RX_CLK,
   input  logic                       RST,
   input  logic [DATA_W-1:0]          DATA,
   input  logic                       ENA,
   output logic                       FULL,
   output logic [$clog2(DEPTH):0]     LEVEL,
   output logic                       BUSY,
   output logic                       TX_DATA,
   output logic                       TX_LOAD,
   output logic                       TX_STOP
);

   localparam int FW = frame_w(ADDR_W, DATA_W);
   localparam int CW = $clog2(FW);

   localparam logic [1:0] IDLE   = S_IDLE;
   localparam logic [1:0] SHIFT  = S_SHIFT;
   localparam logic [1:0] GAP_ST = S_GAP;

   logic [1:0]        state;
   logic [FW-1:0]     shreg;
   logic [FW-1:0]     frame;
   logic [CW-1:0]     bit_cnt;
   logic [3:0]        gap_cnt;
   logic              tx_data_q, tx_stop_q;
   logic [DATA_W-1:0] head;
   logic              empty, push, pop, final_bit;
   logic [ADDR_W-1:0] addr_c, addr_o;
   logic [DATA_W-1:0] data_o;

   assign addr_c = ADDR_W'(ADDR);

   // Fields are reordered so the shifter always sends frame[FW-1] first.
   if (MSB_FIRST != 0) begin : g_msb
      assign addr_o = addr_c;
      assign data_o = head;
   end else begin : g_lsb
      for (genvar i = 0; i < ADDR_W; i++) begin : g_a
         assign addr_o[i] = addr_c[ADDR_W-1-i];
      end
      for (genvar i = 0; i < DATA_W; i++) begin : g_d
         assign data_o[i] = head[DATA_W-1-i];
      end
   end

`ifdef SPI_PARITY_EN
   assign frame = {addr_o, data_o, parity_even(40'({addr_c, head}))};
`else
   assign frame = {addr_o, data_o};
`endif

   spi_out_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk     (RX_CLK),
      .rst     (RST),
      .wr_en   (ENA),
      .wr_data (DATA),
      .rd_en   (pop),
      .rd_data (head),
      .level   (LEVEL),
      .full    (FULL),
      .empty   (empty)
   );

   assign push      = ENA && !FULL;
   assign final_bit = (state == SHIFT) && (bit_cnt == CW'(FW-1));
   // With no gap the next word is popped on the final bit for a seamless reload.
   assign pop       = !empty && ((state == IDLE) || (final_bit && GAP == 0));

   always_ff @(posedge RX_CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         tx_data_q <= 1'b0;
         tx_stop_q <= 1'b0;
      end else begin
         tx_stop_q <= final_bit && empty && !push;
         case (state)
            IDLE: begin
               tx_data_q <= 1'b0;
               if (!empty) begin
                  tx_data_q <= frame[FW-1];
                  shreg     <= {frame[FW-2:0], 1'b0};
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (!final_bit) begin
                  tx_data_q <= shreg[FW-1];
                  shreg     <= {shreg[FW-2:0], 1'b0};
                  bit_cnt   <= bit_cnt + CW'(1);
               end else if (GAP > 0) begin
                  tx_data_q <= 1'b0;
                  gap_cnt   <= '0;
                  state     <= GAP_ST;
               end else if (!empty) begin
                  tx_data_q <= frame[FW-1];
                  shreg     <= {frame[FW-2:0], 1'b0};
                  bit_cnt   <= '0;
               end else begin
                  tx_data_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            GAP_ST: begin
               tx_data_q <= 1'b0;
               if (gap_cnt == 4'(GAP-1)) state <= IDLE;
               else                      gap_cnt <= gap_cnt + 4'd1;
            end
            default: begin
               tx_data_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign TX_DATA = tx_data_q;
   assign TX_STOP = tx_stop_q;
   assign TX_LOAD = final_bit;
   assign BUSY    = !empty || (state != IDLE);

endmodule

// File: tb/tb_output_spi_framer.sv
// Scoreboard bench for output_spi_framer: three instances (default, GAP=0, LSB-first).
module tb_output_spi_framer;

`ifdef SPI_PARITY_EN
   localparam int FW = 20;
`else
   localparam int FW = 19;
`endif

   typedef struct {
      logic [63:0] frame;
      int          cyc;
      bit          stop;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data = '0;
   logic [2:0]  ena = '0;
   logic [2:0]  txd, tld, tst, bsy, ful;
   logic [2:0]  lvl0, lvl1, lvl2;

   int   cyc = 0;
   int   act = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   output_spi_framer #(.MSB_FIRST(1), .GAP(1)) u0 (
      .RX_CLK(clk), .RST(rst), .DATA(data), .ENA(ena[0]), .FULL(ful[0]), .LEVEL(lvl0),
      .BUSY(bsy[0]), .TX_DATA(txd[0]), .TX_LOAD(tld[0]), .TX_STOP(tst[0]));
   output_spi_framer #(.MSB_FIRST(1), .GAP(0)) u1 (
      .RX_CLK(clk), .RST(rst), .DATA(data), .ENA(ena[1]), .FULL(ful[1]), .LEVEL(lvl1),
      .BUSY(bsy[1]), .TX_DATA(txd[1]), .TX_LOAD(tld[1]), .TX_STOP(tst[1]));
   output_spi_framer #(.MSB_FIRST(0), .GAP(1)) u2 (
      .RX_CLK(clk), .RST(rst), .DATA(data), .ENA(ena[2]), .FULL(ful[2]), .LEVEL(lvl2),
      .BUSY(bsy[2]), .TX_DATA(txd[2]), .TX_LOAD(tld[2]), .TX_STOP(tst[2]));

   function automatic logic [63:0] mk(input logic [18:0] f);
`ifdef SPI_PARITY_EN
      return 64'({f, ^f});
`else
      return 64'(f);
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   task automatic expect_frame(input logic [63:0] f, input int c, input bit s);
      exp_t e;
      e.frame = f; e.cyc = c; e.stop = s;
      exp_q.push_back(e);
   endtask

   // Holds ENA high across calls; caller lowers it after the last word.
   task automatic drive(input int inst, input logic [15:0] d);
      data = d;
      ena[inst] = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic monitor();
      logic [63:0] hist = '0;
      bit          stop_pend = 0;
      bit          stop_want = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         hist = {hist[62:0], txd[act]};
         if (stop_pend) begin
            check("tx_stop", 64'(tst[act]), 64'(stop_want));
            stop_pend = 0;
         end
         if (tld[act]) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 64'(hist[FW-1:0]), 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("frame", 64'(hist[FW-1:0]), e.frame);
               if (e.cyc != 0) check("load_cycle", 64'(cyc), 64'(e.cyc));
               stop_pend = 1;
               stop_want = e.stop;
            end
         end
      end
   endtask

   initial begin
      int n;
      fork monitor(); join_none

      // Reset values
      #2;
      check("rst_tx_data", 64'(txd[0]), 0);
      check("rst_tx_load", 64'(tld[0]), 0);
      check("rst_tx_stop", 64'(tst[0]), 0);
      check("rst_busy",    64'(bsy[0]), 0);
      check("rst_level",   64'(lvl0),   0);
      check("rst_full",    64'(ful[0]), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1: single word 0xA5C3, default parameters
      act = 0;
      @(posedge clk); #1;
      n = cyc;
`ifdef SPI_PARITY_EN
      expect_frame(64'({3'b001, 16'hA5C3, 1'b1}), n + 1 + FW, 1);
`else
      expect_frame(64'({3'b001, 16'hA5C3}), n + 1 + FW, 1);
`endif
      drive(0, 16'hA5C3);
      ena[0] = 1'b0;
      repeat (FW + 1) @(posedge clk);
      #1 check("busy_in_gap", 64'(bsy[0]), 1);
      @(posedge clk); #1;
      check("busy_after_stop", 64'(bsy[0]), 0);
      repeat (5) @(posedge clk);

      // 2: GAP=0, four back-to-back words, contiguous frames
      act = 1;
      @(posedge clk); #1;
      n = cyc;
      expect_frame(mk({3'b001, 16'h0001}), n + 1 + FW,     0);
      expect_frame(mk({3'b001, 16'h8000}), n + 1 + 2 * FW, 0);
      expect_frame(mk({3'b001, 16'hFFFF}), n + 1 + 3 * FW, 0);
      expect_frame(mk({3'b001, 16'h0000}), n + 1 + 4 * FW, 1);
      drive(1, 16'h0001); drive(1, 16'h8000); drive(1, 16'hFFFF); drive(1, 16'h0000);
      ena[1] = 1'b0;
      repeat (4 * FW + 6) @(posedge clk);
      #1 check("t2_busy_end", 64'(bsy[1]), 0);

      // 3: overflow while the first frame shifts
      act = 0;
      @(posedge clk); #1;
      n = cyc;
      expect_frame(mk({3'b001, 16'h1234}), n + 1 + FW,       0);
      expect_frame(mk({3'b001, 16'h1111}), n + 1 + 2 * FW + 2, 0);
      expect_frame(mk({3'b001, 16'h2222}), 0, 0);
      expect_frame(mk({3'b001, 16'h3333}), 0, 0);
      expect_frame(mk({3'b001, 16'h4444}), 0, 1);
      drive(0, 16'h1234);
      ena[0] = 1'b0;
      @(posedge clk); #1;
      check("t3_level_popped", 64'(lvl0), 0);
      drive(0, 16'h1111); drive(0, 16'h2222); drive(0, 16'h3333);
      check("t3_level3", 64'(lvl0), 3);
      check("t3_not_full", 64'(ful[0]), 0);
      drive(0, 16'h4444);
      check("t3_level4", 64'(lvl0), 4);
      check("t3_full", 64'(ful[0]), 1);
      drive(0, 16'h5555); drive(0, 16'h6666);
      ena[0] = 1'b0;
      check("t3_level_capped", 64'(lvl0), 4);
      check("t3_full_held", 64'(ful[0]), 1);
      repeat (5 * (FW + 2) + 10) @(posedge clk);
      #1 check("t3_busy_end", 64'(bsy[0]), 0);

      // 4: LSB-first ordering
      act = 2;
      @(posedge clk); #1;
      n = cyc;
      expect_frame(mk({3'b100, 16'b1100_0000_0000_0000}), n + 1 + FW, 1);
      drive(2, 16'h0003);
      ena[2] = 1'b0;
      repeat (FW + 6) @(posedge clk);

      // 5: reset at bit 7 with two words queued
      act = 0;
      @(posedge clk); #1;
      drive(0, 16'hFFFF); drive(0, 16'hFFFF); drive(0, 16'hFFFF);
      ena[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("t5_bit7", 64'(txd[0]), 1);
      check("t5_level_queued", 64'(lvl0), 2);
      rst = 1'b1;
      #1;
      check("t5_async_tx_data", 64'(txd[0]), 0);
      check("t5_async_level",   64'(lvl0),   0);
      check("t5_async_busy",    64'(bsy[0]), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3 * FW) @(posedge clk);
      #1 check("t5_level_after", 64'(lvl0), 0);
      check("t5_busy_after", 64'(bsy[0]), 0);

      check("frames_outstanding", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
